cmp_stream_unit: RTL and testbench
==================================

CMP_STREAM_UNIT -- requirements
Module: cmp_stream_unit

Interface
REQ-001 Parameter DATA_W, default 16, operand and result width (min 2).
REQ-002 Parameter CNT_W, default 8, sample counter width (min 2).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand transaction offered.
REQ-006 in_ready  output  1  unit can accept a transaction this cycle.
REQ-007 A, B  input  DATA_W each  operands.
REQ-008 fn  input  3  operation code.
REQ-009 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-010 clear  input  1  synchronous tracker clear.
REQ-011 out_valid  output  1  result register holds a valid result.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 cmp_out  output  DATA_W  result code or selected value.
REQ-014 cmp_flag  output  1  result predicate.
REQ-015 min_val, max_val  output  DATA_W each  running extrema of accepted A.
REQ-016 sample_cnt  output  CNT_W  accepted-sample count since clear/reset.
REQ-017 cnt_sat  output  1  sample_cnt saturated.

Function
REQ-018 Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-019 Latency one cycle: result of an accepted transaction appears on cmp_out/cmp_flag with out_valid=1 the next cycle.
REQ-020 While out_valid && !out_ready, cmp_out, cmp_flag and out_valid hold unchanged.
REQ-021 out_valid clears after a cycle with out_ready=1 and no accept; back-to-back accept with out_ready=1 keeps out_valid=1 (full throughput).
REQ-022 fn codes: 000 NOP, 001 EQ, 010 GT, 011 LT, 100 GE, 101 LE, 110 MIN, 111 MAX.
REQ-023 NOP: cmp_out=0, cmp_flag=0.
REQ-024 Compare ops: cmp_flag=predicate; cmp_out = code (EQ 1, GT 2, LT 3, GE 4, LE 5) zero-extended when true, else 0.
REQ-025 MIN/MAX: cmp_out = selected operand; cmp_flag=1 when A selected; on A==B, A selected, cmp_flag=1.
REQ-026 Ordering is signed when signed_mode=1, unsigned otherwise, sampled with the transaction.
REQ-027 Tracker states EMPTY, TRACKING; EMPTY after reset or clear.
REQ-028 EMPTY + accept: min_val=max_val=A, sample_cnt=1, go TRACKING.
REQ-029 TRACKING + accept: min_val=min(min_val,A), max_val=max(max_val,A) per transaction's signed_mode; sample_cnt+1.
REQ-030 sample_cnt saturates at 2^CNT_W-1; cnt_sat=1 from then until clear/reset; extrema keep updating.
REQ-031 clear without accept: min_val=max_val=0, sample_cnt=0, cnt_sat=0, EMPTY.
REQ-032 clear with accept same cycle: tracker behaves as EMPTY + accept (sample_cnt=1); result path unaffected by clear.
REQ-033 Tracker updates on every accept, including NOP.

Reset
REQ-034 rst low forces out_valid=0, cmp_out=0, cmp_flag=0, min_val=0, max_val=0, sample_cnt=0, cnt_sat=0, tracker EMPTY immediately, regardless of clk.
REQ-035 Reset mid-transaction discards any pending result; in_ready=1 after reset release.

Structure
REQ-036 Package cmp_pkg holds fn code constants, result code constants (EQ..LE) and the tracker state enumeration.
REQ-037 Sub-module cmp_core: combinational DATA_W-parametrised compare producing eq/gt/lt under signed_mode; instantiated for A-vs-B, A-vs-min_val, A-vs-max_val.

Verification
REQ-038 signed_mode=1, A=16'hFFFF, B=16'h0001, fn=LT -> cmp_out=3, cmp_flag=1; same with signed_mode=0 -> cmp_out=0, cmp_flag=0.
REQ-039 fn=GE, A=B=16'h1234 -> cmp_out=4, cmp_flag=1; fn=MAX, A=5, B=9 -> cmp_out=9, cmp_flag=0.
REQ-040 Result pending, out_ready=0 for 3 cycles -> in_ready=0, outputs stable; out_ready=1 with new in_valid -> next result next cycle, no bubble.
REQ-041 Signed stream A = 3, -7, 12, 0 -> min_val=16'hFFF9, max_val=12, sample_cnt=4; clear alone -> all 0, EMPTY.
REQ-042 CNT_W=2, 5 accepts -> sample_cnt=3, cnt_sat=1 after 3rd; clear+accept with A=8 -> min=max=8, sample_cnt=1, cnt_sat=0.
REQ-043 rst low asynchronously with out_valid=1 -> all outputs 0 same cycle; after release in_ready=1.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared constants for the compare/stream unit: operation codes, result codes
// and the extrema-tracker state type.
package cmp_pkg;

  localparam logic [2:0] FN_NOP = 3'b000;
  localparam logic [2:0] FN_EQ  = 3'b001;
  localparam logic [2:0] FN_GT  = 3'b010;
  localparam logic [2:0] FN_LT  = 3'b011;
  localparam logic [2:0] FN_GE  = 3'b100;
  localparam logic [2:0] FN_LE  = 3'b101;
  localparam logic [2:0] FN_MIN = 3'b110;
  localparam logic [2:0] FN_MAX = 3'b111;

  localparam logic [2:0] RES_EQ = 3'd1;
  localparam logic [2:0] RES_GT = 3'd2;
  localparam logic [2:0] RES_LT = 3'd3;
  localparam logic [2:0] RES_GE = 3'd4;
  localparam logic [2:0] RES_LE = 3'd5;

  typedef enum logic {
    TRK_EMPTY    = 1'b0,
    TRK_TRACKING = 1'b1
  } trk_state_e;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude compare; signed ordering is obtained by flipping
// the sign bits so a single unsigned comparator serves both modes.
module cmp_core #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_mode,
  output logic              eq,
  output logic              gt,
  output logic              lt
);

  logic [DATA_W-1:0] a_x;
  logic [DATA_W-1:0] b_x;

  assign a_x = {a[DATA_W-1] ^ signed_mode, a[DATA_W-2:0]};
  assign b_x = {b[DATA_W-1] ^ signed_mode, b[DATA_W-2:0]};

  assign eq = (a_x == b_x);
  assign gt = (a_x >  b_x);
  assign lt = (a_x <  b_x);

endmodule

// File: rtl/cmp_stream_unit.sv
// One-cycle compare/select pipeline stage with valid/ready handshake and a
// running min/max/count tracker over every accepted A operand.
module cmp_stream_unit
  import cmp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        fn,
  input  logic              signed_mode,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] cmp_out,
  output logic              cmp_flag,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              cnt_sat
);

  logic accept;
  logic ab_eq, ab_gt, ab_lt;
  logic amin_eq, amin_gt, amin_lt;
  logic amax_eq, amax_gt, amax_lt;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] cmp_out_q, cmp_out_d;
  logic              cmp_flag_q, cmp_flag_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  trk_state_e        state_q, state_d;
  logic [DATA_W-1:0] res_out;
  logic              res_flag;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  cmp_core #(.DATA_W(DATA_W)) u_cmp_ab (
    .a(A), .b(B), .signed_mode(signed_mode), .eq(ab_eq), .gt(ab_gt), .lt(ab_lt)
  );
  cmp_core #(.DATA_W(DATA_W)) u_cmp_min (
    .a(A), .b(min_q), .signed_mode(signed_mode), .eq(amin_eq), .gt(amin_gt), .lt(amin_lt)
  );
  cmp_core #(.DATA_W(DATA_W)) u_cmp_max (
    .a(A), .b(max_q), .signed_mode(signed_mode), .eq(amax_eq), .gt(amax_gt), .lt(amax_lt)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    res_out  = '0;
    res_flag = 1'b0;
    case (fn)
      FN_EQ: begin res_flag = ab_eq;          res_out = res_flag ? DATA_W'(RES_EQ) : '0; end
      FN_GT: begin res_flag = ab_gt;          res_out = res_flag ? DATA_W'(RES_GT) : '0; end
      FN_LT: begin res_flag = ab_lt;          res_out = res_flag ? DATA_W'(RES_LT) : '0; end
      FN_GE: begin res_flag = ab_gt || ab_eq; res_out = res_flag ? DATA_W'(RES_GE) : '0; end
      FN_LE: begin res_flag = ab_lt || ab_eq; res_out = res_flag ? DATA_W'(RES_LE) : '0; end
      FN_MIN: begin res_flag = ab_lt || ab_eq; res_out = res_flag ? A : B; end
      FN_MAX: begin res_flag = ab_gt || ab_eq; res_out = res_flag ? A : B; end
      default: ;
    endcase
  end

  // Result register: a stalled result holds until downstream takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    cmp_out_d   = cmp_out_q;
    cmp_flag_d  = cmp_flag_q;
    if (accept) begin
      out_valid_d = 1'b1;
      cmp_out_d   = res_out;
      cmp_flag_d  = res_flag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear together with accept restarts the tracker from this sample.
  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (accept) begin
      if (clear || state_q == TRK_EMPTY) begin
        min_d   = A;
        max_d   = A;
        cnt_d   = CNT_W'(1);
        state_d = TRK_TRACKING;
      end else begin
        if (amin_lt || amin_eq) min_d = A;
        if (amax_gt || amax_eq) max_d = A;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (clear) begin
      min_d   = '0;
      max_d   = '0;
      cnt_d   = '0;
      state_d = TRK_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      cmp_out_q   <= '0;
      cmp_flag_q  <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      state_q     <= TRK_EMPTY;
    end else begin
      out_valid_q <= out_valid_d;
      cmp_out_q   <= cmp_out_d;
      cmp_flag_q  <= cmp_flag_d;
      min_q       <= min_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign cmp_out    = cmp_out_q;
  assign cmp_flag   = cmp_flag_q;
  assign min_val    = min_q;
  assign max_val    = max_q;
  assign sample_cnt = cnt_q;
  assign cnt_sat    = &cnt_q;

endmodule

// File: tb/tb_cmp_stream_unit.sv
// Randomized and directed checks of cmp_stream_unit against a behavioural
// model that orders operands as plain integers.
module tb_cmp_stream_unit;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] A, B;
  logic [2:0]    fn;
  logic          signed_mode, clear;
  logic          out_valid, out_ready;
  logic [DW-1:0] cmp_out;
  logic          cmp_flag;
  logic [DW-1:0] min_val, max_val;
  logic [CW-1:0] sample_cnt;
  logic          cnt_sat;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_valid;
  logic [DW-1:0] m_out;
  bit            m_flag;
  logic [DW-1:0] m_min, m_max;
  int            m_cnt;
  bit            m_empty;

  always #5 clk = ~clk;

  cmp_stream_unit #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .fn(fn), .signed_mode(signed_mode), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .cmp_out(cmp_out),
    .cmp_flag(cmp_flag), .min_val(min_val), .max_val(max_val),
    .sample_cnt(sample_cnt), .cnt_sat(cnt_sat)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ord(logic [DW-1:0] v, bit sm);
    if (sm) return int'($signed(v));
    return int'(v);
  endfunction

  function automatic void model_res(input logic [2:0] f, input logic [DW-1:0] a, b,
                                    input bit sm, output logic [DW-1:0] o, output bit fl);
    int ia = ord(a, sm);
    int ib = ord(b, sm);
    o  = '0;
    fl = 1'b0;
    case (f)
      3'd1: begin fl = (ia == ib); o = fl ? 16'd1 : 16'd0; end
      3'd2: begin fl = (ia >  ib); o = fl ? 16'd2 : 16'd0; end
      3'd3: begin fl = (ia <  ib); o = fl ? 16'd3 : 16'd0; end
      3'd4: begin fl = (ia >= ib); o = fl ? 16'd4 : 16'd0; end
      3'd5: begin fl = (ia <= ib); o = fl ? 16'd5 : 16'd0; end
      3'd6: begin fl = (ia <= ib); o = fl ? a : b; end
      3'd7: begin fl = (ia >= ib); o = fl ? a : b; end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_out = '0; m_flag = 0;
    m_min = '0; m_max = '0; m_cnt = 0; m_empty = 1;
  endtask

  task automatic check_outputs(string tag);
    check({tag, ".out_valid"}, out_valid, m_valid);
    if (m_valid) begin
      check({tag, ".cmp_out"}, cmp_out, m_out);
      check({tag, ".cmp_flag"}, cmp_flag, m_flag);
    end
    check({tag, ".min_val"}, min_val, m_min);
    check({tag, ".max_val"}, max_val, m_max);
    check({tag, ".sample_cnt"}, sample_cnt, m_cnt);
    check({tag, ".cnt_sat"}, cnt_sat, m_cnt == CNT_MAX);
  endtask

  // One clock: drive inputs, check in_ready, advance model and DUT, compare.
  task automatic cycle(string tag, bit v, logic [2:0] f, logic [DW-1:0] a, b,
                       bit sm, bit clr, bit ordy);
    bit acc;
    in_valid = v; fn = f; A = a; B = b; signed_mode = sm; clear = clr; out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, in_ready, !m_valid || ordy);
    acc = v && (!m_valid || ordy);
    if (acc) begin
      m_valid = 1;
      model_res(f, a, b, sm, m_out, m_flag);
    end else if (ordy) begin
      m_valid = 0;
    end
    if (acc) begin
      if (clr || m_empty) begin
        m_min = a; m_max = a; m_cnt = 1; m_empty = 0;
      end else begin
        if (ord(a, sm) < ord(m_min, sm)) m_min = a;
        if (ord(a, sm) > ord(m_max, sm)) m_max = a;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else if (clr) begin
      m_min = '0; m_max = '0; m_cnt = 0; m_empty = 1;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 0; A = '0; B = '0; fn = '0; signed_mode = 0; clear = 0; out_ready = 0;
    model_reset();
    #3;
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.sample_cnt", sample_cnt, '0);
    check("reset.in_ready", in_ready, 1'b1);
    #9 rst = 1'b1;

    // Signed versus unsigned ordering of 0xFFFF against 1
    cycle("lt_signed", 1, 3'd3, 16'hFFFF, 16'h0001, 1, 0, 1);
    check("lt_signed.code", cmp_out, 16'd3);
    check("lt_signed.flag", cmp_flag, 1'b1);
    cycle("lt_unsigned", 1, 3'd3, 16'hFFFF, 16'h0001, 0, 0, 1);
    check("lt_unsigned.code", cmp_out, 16'd0);
    check("lt_unsigned.flag", cmp_flag, 1'b0);

    // GE on equal operands, then stall three cycles while a new offer waits
    cycle("ge_eq", 1, 3'd4, 16'h1234, 16'h1234, 0, 0, 1);
    check("ge_eq.code", cmp_out, 16'd4);
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1, 3'd7, 16'd5, 16'd9, 0, 0, 0);
      check("stall.in_ready", in_ready, 1'b0);
      check("stall.hold", cmp_out, 16'd4);
    end
    cycle("max_nobubble", 1, 3'd7, 16'd5, 16'd9, 0, 0, 1);
    check("max.code", cmp_out, 16'd9);
    check("max.flag", cmp_flag, 1'b0);
    check("max.valid", out_valid, 1'b1);

    // Signed extrema stream after a fresh clear
    cycle("clr0", 0, 3'd0, 16'd0, 16'd0, 0, 1, 1);
    cycle("s0", 1, 3'd0, 16'd3, 16'd0, 1, 0, 1);
    cycle("s1", 1, 3'd0, 16'hFFF9, 16'd0, 1, 0, 1);
    cycle("s2", 1, 3'd0, 16'd12, 16'd0, 1, 0, 1);
    cycle("s3", 1, 3'd0, 16'd0, 16'd0, 1, 0, 1);
    check("stream.min", min_val, 16'hFFF9);
    check("stream.max", max_val, 16'd12);
    check("stream.cnt", sample_cnt, 8'd4);
    cycle("clr_alone", 0, 3'd0, 16'd0, 16'd0, 1, 1, 1);
    check("clr_alone.cnt", sample_cnt, 8'd0);
    check("clr_alone.min", min_val, 16'd0);

    // Saturation, then clear coincident with accept
    for (int i = 0; i < CNT_MAX + 5; i++)
      cycle("sat", 1, 3'($urandom_range(7)), 16'($urandom), 16'($urandom), 1'($urandom), 0, 1);
    check("sat.cnt", sample_cnt, 8'hFF);
    check("sat.flag", cnt_sat, 1'b1);
    cycle("clr_acc", 1, 3'd1, 16'd8, 16'd8, 0, 1, 1);
    check("clr_acc.min", min_val, 16'd8);
    check("clr_acc.max", max_val, 16'd8);
    check("clr_acc.cnt", sample_cnt, 8'd1);
    check("clr_acc.sat", cnt_sat, 1'b0);

    // Random traffic with back-pressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] ra, rb;
      ra = ($urandom_range(3) == 0) ? 16'($urandom_range(4)) : 16'($urandom);
      rb = ($urandom_range(3) == 0) ? ra : 16'($urandom);
      cycle("rand", $urandom_range(3) != 0, 3'($urandom_range(7)), ra, rb,
            1'($urandom), $urandom_range(15) == 0, $urandom_range(3) != 0);
    end

    // Asynchronous reset while a result is pending
    cycle("pend", 1, 3'd7, 16'd1, 16'd2, 0, 0, 0);
    check("pend.valid", out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst.out_valid", out_valid, 1'b0);
    check("arst.cmp_out", cmp_out, 16'd0);
    check("arst.cmp_flag", cmp_flag, 1'b0);
    check("arst.min", min_val, 16'd0);
    check("arst.max", max_val, 16'd0);
    check("arst.cnt", sample_cnt, 8'd0);
    check("arst.sat", cnt_sat, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst.in_ready", in_ready, 1'b1);
    cycle("post_rst", 1, 3'd2, 16'd7, 16'd3, 0, 0, 0);
    check("post_rst.code", cmp_out, 16'd2);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
